// File: rtl/ring_sequencer.sv
// Ring/shift sequencer: single steps, multi-step runs and ping-pong bouncing over a LENGTH-bit register.
// Steps land on the clock edge and done/wrap are registered one-cycle pulses. There is no backpressure; a load aborts a run.
module ring_sequencer #(
  parameter int                LENGTH      = 4,
  parameter logic [LENGTH-1:0] RESET_VALUE = {{(LENGTH-1){1'b0}}, 1'b1},
  parameter int                AMT_W       = $clog2(LENGTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic              load,
  input  logic [LENGTH-1:0] loadValue,
  input  logic              serialIn,
  input  logic              start,
  input  logic [AMT_W-1:0]  amount,
  input  logic              outputEnable,
  output logic [LENGTH-1:0] out,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              dir
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [LENGTH-1:0] shreg;
  logic [LENGTH-1:0] nxt_reg;
  logic [AMT_W-1:0]  cnt;
  logic [1:0]        run_mode;
  logic [1:0]        step_mode;
  logic              nxt_dir;
  logic              nxt_wrap;

  // A run is locked to the mode captured at start.
  assign step_mode = (state == RUN) ? run_mode : mode;

  always_comb begin
    nxt_reg  = shreg;
    nxt_dir  = dir;
    nxt_wrap = 1'b0;
    case (step_mode)
      2'b00: begin
        nxt_reg  = {shreg[LENGTH-2:0], shreg[LENGTH-1]};
        nxt_wrap = shreg[LENGTH-1];
      end
      2'b01: begin
        nxt_reg  = {shreg[0], shreg[LENGTH-1:1]};
        nxt_wrap = shreg[0];
      end
      2'b10: begin
        nxt_reg  = {shreg[LENGTH-2:0], serialIn};
        nxt_wrap = shreg[LENGTH-1];
      end
      default: begin
        // Ping-pong: reaching an end reverses direction on that same step.
        if (!dir) begin
          if (shreg[LENGTH-1]) begin
            nxt_reg  = {1'b0, shreg[LENGTH-1:1]};
            nxt_dir  = 1'b1;
            nxt_wrap = 1'b1;
          end else begin
            nxt_reg  = {shreg[LENGTH-2:0], 1'b0};
          end
        end else begin
          if (shreg[0]) begin
            nxt_reg  = {shreg[LENGTH-2:0], 1'b0};
            nxt_dir  = 1'b0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_reg  = {1'b0, shreg[LENGTH-1:1]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= RESET_VALUE;
      cnt      <= '0;
      run_mode <= 2'b00;
      dir      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          shreg <= loadValue;
        end else if (start) begin
          if (amount != '0) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= amount;
            run_mode <= mode;
          end else begin
            done <= 1'b1;
          end
        end else if (step) begin
          shreg <= nxt_reg;
          dir   <= nxt_dir;
          wrap  <= nxt_wrap;
        end
      end else begin
        if (load) begin
          shreg <= loadValue;
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end else begin
          shreg <= nxt_reg;
          dir   <= nxt_dir;
          wrap  <= nxt_wrap;
          cnt   <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end

  assign out = outputEnable ? shreg : {LENGTH{1'bx}};

endmodule

// File: tb/tb_ring_sequencer.sv
// Scoreboarded bench for ring_sequencer: directed scenarios plus random traffic against an arithmetic reference model.
module tb_ring_sequencer;
  localparam int L    = 4;
  localparam int AW   = 3;
  localparam int MODN = 1 << L;
  localparam int TOPB = 1 << (L - 1);
  localparam int RV   = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          step = 1'b0;
  logic          load = 1'b0;
  logic [L-1:0]  loadValue = '0;
  logic          serialIn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] amount = '0;
  logic          outputEnable = 1'b1;
  logic [L-1:0]  out;
  logic          busy, done, wrap, dir;

  ring_sequencer #(.LENGTH(L), .RESET_VALUE(L'(RV)), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .step(step), .load(load),
    .loadValue(loadValue), .serialIn(serialIn), .start(start), .amount(amount),
    .outputEnable(outputEnable), .out(out), .busy(busy), .done(done),
    .wrap(wrap), .dir(dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    bit busy;
    bit done;
    bit wrap;
    bit dir;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: register as an integer, run bookkeeping as a step budget.
  int m_reg, m_rem, m_mode;
  bit m_dir, m_busy, m_done, m_wrap;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_reg = RV; m_dir = 1'b0; m_busy = 1'b0; m_rem = 0; m_mode = 0;
    m_done = 1'b0; m_wrap = 1'b0;
  endfunction

  function automatic void apply_step(input int md);
    case (md)
      0: begin m_wrap = (m_reg >= TOPB); m_reg = (m_reg * 2) % MODN + m_reg / TOPB; end
      1: begin m_wrap = (m_reg % 2 == 1); m_reg = m_reg / 2 + (m_reg % 2) * TOPB; end
      2: begin m_wrap = (m_reg >= TOPB); m_reg = (m_reg * 2) % MODN + int'(serialIn); end
      default: begin
        if (!m_dir) begin
          if (m_reg >= TOPB) begin m_dir = 1'b1; m_wrap = 1'b1; m_reg = m_reg / 2; end
          else m_reg = (m_reg * 2) % MODN;
        end else begin
          if (m_reg % 2 == 1) begin m_dir = 1'b0; m_wrap = 1'b1; m_reg = (m_reg * 2) % MODN; end
          else m_reg = m_reg / 2;
        end
      end
    endcase
  endfunction

  function automatic void model_tick();
    exp_t e;
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (reset) begin
      model_reset();
    end else if (!m_busy) begin
      if (load) m_reg = int'(loadValue);
      else if (start) begin
        if (amount == 0) m_done = 1'b1;
        else begin m_busy = 1'b1; m_rem = int'(amount); m_mode = int'(mode); end
      end else if (step) apply_step(int'(mode));
    end else begin
      if (load) begin m_reg = int'(loadValue); m_busy = 1'b0; end
      else begin
        apply_step(m_mode);
        m_rem--;
        if (m_rem == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end
    end
    e.r = m_reg; e.busy = m_busy; e.done = m_done; e.wrap = m_wrap; e.dir = m_dir;
    sbq.push_back(e);
  endfunction

  task automatic drive(input bit ld, input int lv, input bit st, input int amt,
                       input bit sp, input int md, input bit si, input bit oe);
    load = ld; loadValue = L'(lv); start = st; amount = AW'(amt);
    step = sp; mode = 2'(md); serialIn = si; outputEnable = oe;
  endtask

  task automatic drive_idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    sbq.delete();
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        if (outputEnable) check("sb_out", int'(out), e.r);
        check("sb_busy", int'(busy), int'(e.busy));
        check("sb_done", int'(done), int'(e.done));
        check("sb_wrap", int'(wrap), int'(e.wrap));
        check("sb_dir", int'(dir), int'(e.dir));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    model_reset();
    tick();
    tick();
    check("rst_out", int'(out), RV);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Mode 00 rotate: 0001 walks round and returns, wrapping on the fourth step.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b1);
      tick();
    end
    drive_idle();
    tick();
    check("rot4_out", int'(out), 1);

    // Ping-pong from 0001: bounces at the top after step 4 and at the bottom after step 7.
    drive(1'b1, 1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0, 1'b1);
      tick();
    end
    drive_idle();
    check("pp_out", int'(out), 4);
    check("pp_dir", int'(dir), 0);
    tick();

    // Load 0110 then rotate right by 3: start-to-done latency of 4 cycles.
    drive(1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1, 3, 1'b0, 1, 1'b0, 1'b1);
    lat = 0;
    do begin
      tick();
      lat++;
      drive_idle();
    end while (!done && lat < 10);
    check("run_latency", lat, 4);
    check("run_out", int'(out), 12);
    tick();

    // Load during the second RUN cycle aborts the run with no done pulse.
    drive(1'b0, 0, 1'b1, 5, 1'b0, 0, 1'b0, 1'b1);
    tick();
    drive_idle();
    tick();
    drive(1'b1, 10, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    drive_idle();
    for (int i = 0; i < 6; i++) tick();
    check("abort_out", int'(out), 10);
    check("abort_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a ping-pong run that has already flipped dir.
    drive(1'b1, 8, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1, 5, 1'b0, 3, 1'b0, 1'b1);
    tick();
    drive_idle();
    tick();
    #2;
    assert_reset();
    #1;
    check("arst_out", int'(out), RV);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_wrap", int'(wrap), 0);
    check("arst_dir", int'(dir), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // start with amount 0 beats step: register unchanged, immediate done, output gated.
    drive(1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    check("amt0_done", int'(done), 1);
    check("amt0_busy", int'(busy), 0);
    tick();
    drive_idle();
    tick();
    check("amt0_out", int'(out), 5);

    // Random traffic, including occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        assert_reset();
        tick();
        reset = 1'b0;
        continue;
      end
      drive($urandom_range(0, 11) == 0, int'($urandom_range(0, MODN - 1)),
            $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      tick();
    end

    drive_idle();
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    #1;
    check("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
